// File: rtl/count_seq_if.sv
// Run-control bundle between a requester and the count sequencer.
// Carries the run request, the configuration, and the counter and status outputs.
interface count_seq_if #(
    parameter int WIDTH = 4,
    parameter int RPT_W = 4
);
    logic             start;
    logic             pause;
    logic             abort;
    logic [WIDTH-1:0] cfg_start;
    logic [WIDTH-1:0] cfg_limit;
    logic [WIDTH-1:0] cfg_step;
    logic [RPT_W-1:0] cfg_repeat;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;
    logic             cfg_err;
    logic [RPT_W-1:0] pass_cnt;

    modport master (
        output start, pause, abort, cfg_start, cfg_limit, cfg_step, cfg_repeat,
        input  q, busy, done, cfg_err, pass_cnt
    );

    modport slave (
        input  start, pause, abort, cfg_start, cfg_limit, cfg_step, cfg_repeat,
        output q, busy, done, cfg_err, pass_cnt
    );
endinterface

// File: rtl/count_sequencer.sv
// Sequences a programmable up-counter: sweeps start..limit by step, repeating
// cfg_repeat extra times, with pause/abort control and busy/done/cfg_err status.
module count_sequencer #(
    parameter int WIDTH = 4,
    parameter int RPT_W = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    count_seq_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] q_r, q_n;
    logic [RPT_W-1:0] pc_r, pc_n;
    logic             done_r, done_n;
    logic             err_r, err_n;
    logic             sh_load;
    logic [WIDTH-1:0] start_s, limit_s, step_s;
    logic [RPT_W-1:0] rpt_s;
    logic [WIDTH:0]   sum;
    logic             cfg_bad;

    // One extra bit so a limit of all-ones ends the pass instead of wrapping.
    assign sum     = {1'b0, q_r} + {1'b0, step_s};
    assign cfg_bad = (bus.cfg_start > bus.cfg_limit) || (bus.cfg_step == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            q_r     <= '0;
            pc_r    <= '0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            start_s <= '0;
            limit_s <= '0;
            step_s  <= '0;
            rpt_s   <= '0;
        end else begin
            state  <= state_n;
            q_r    <= q_n;
            pc_r   <= pc_n;
            done_r <= done_n;
            err_r  <= err_n;
            if (sh_load) begin
                start_s <= bus.cfg_start;
                limit_s <= bus.cfg_limit;
                step_s  <= bus.cfg_step;
                rpt_s   <= bus.cfg_repeat;
            end
        end
    end

    always_comb begin
        state_n = state;
        q_n     = q_r;
        pc_n    = pc_r;
        done_n  = 1'b0;
        err_n   = 1'b0;
        sh_load = 1'b0;
        if (bus.abort) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        sh_load = 1'b1;
                        if (cfg_bad) begin
                            err_n = 1'b1;
                        end else begin
                            q_n     = bus.cfg_start;
                            pc_n    = '0;
                            state_n = RUN;
                        end
                    end
                end
                RUN: begin
                    if (bus.pause) begin
                        state_n = PAUSE;
                    end else if (sum <= {1'b0, limit_s}) begin
                        q_n = sum[WIDTH-1:0];
                    end else if (pc_r == rpt_s) begin
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        // Next pass starts back-to-back, no idle cycle.
                        pc_n = pc_r + 1'b1;
                        q_n  = start_s;
                    end
                end
                PAUSE: begin
                    if (!bus.pause) state_n = RUN;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign bus.q        = q_r;
    assign bus.busy     = (state != IDLE);
    assign bus.done     = done_r;
    assign bus.cfg_err  = err_r;
    assign bus.pass_cnt = pc_r;
endmodule

// File: doc/count_sequencer.md
Name: count_sequencer

Overview:
- Controller that sequences a programmable up-counter datapath.
- Latches a start value, limit, step and repeat count on a start request.
- Steps the counter output from start to limit, re-running the sweep `cfg_repeat` extra times, with pause and abort control.
- Reports busy and done status and rejects invalid configurations; it is the run-control front end for simple counter datapaths in the design.

Parameters:
- WIDTH, 4, bit width of counter value and of cfg_start/cfg_limit/cfg_step
- RPT_W, 4, bit width of cfg_repeat and pass_cnt

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- start  input  1  run request, sampled only in IDLE
- pause  input  1  level; freezes counting while high during a run
- abort  input  1  terminate run immediately, highest priority
- cfg_start  input  WIDTH  first count value of each pass
- cfg_limit  input  WIDTH  last permitted count value
- cfg_step  input  WIDTH  increment per cycle, must be nonzero
- cfg_repeat  input  RPT_W  extra passes; total passes = cfg_repeat+1
- q  output  WIDTH  counter value (registered)
- busy  output  1  high while state is RUN or PAUSE (registered)
- done  output  1  one-cycle pulse when the final pass completes normally
- cfg_err  output  1  one-cycle pulse when start is rejected
- pass_cnt  output  RPT_W  index of the current pass, 0-based

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - q=0, busy=0, done=0, cfg_err=0, pass_cnt=0.
  - State=IDLE; shadow registers cleared.
  - Reset asserted mid-run aborts the run with no done.
- FSM states are IDLE, RUN and PAUSE; busy = (state != IDLE).
- IDLE, start=1 and abort=0:
  - cfg_* are copied into shadow registers.
  - If cfg_start>cfg_limit or cfg_step==0: cfg_err=1 for one cycle; stay IDLE; q and pass_cnt unchanged.
  - Otherwise: q<=cfg_start, pass_cnt<=0, go to RUN. Latency is one cycle from start sampled to first q value.
- RUN with pause=0:
  - sum = q + step_shadow, computed in WIDTH+1 bits, so there is no wrap-around.
  - If sum <= limit_shadow: q<=sum[WIDTH-1:0].
  - Else, if pass_cnt==repeat_shadow: done=1 for one cycle, go to IDLE, q holds its last value, pass_cnt holds.
  - Else: pass_cnt<=pass_cnt+1 and q<=start_shadow. There is no idle cycle between passes.
- RUN with pause=1: go to PAUSE; q is not updated on that edge.
- PAUSE:
  - q and pass_cnt are frozen.
  - When pause=0, return to RUN; counting resumes on the following edge.
- abort=1 in any state:
  - Next state is IDLE; q and pass_cnt hold; done=0, cfg_err=0.
  - abort has priority over start, pause and pass/limit evaluation.
- While busy:
  - start is ignored.
  - Changes on cfg_* have no effect until the next accepted start.
- start may be asserted in the same cycle done is high, because the state is already IDLE; the new run is accepted.
- done and cfg_err are never high in the same cycle.
- Limit equal to the all-ones value (e.g. limit=15 with WIDTH=4) must terminate correctly with no overflow back to 0.
- Single-value pass (start==limit): q stays at start for one cycle per pass, then done or restart.

Test Plan:
- Reset then start with start=2, limit=10, step=1, repeat=0 -> q=2,3,...,10 on consecutive cycles; done=1 on the cycle after q=10, with q still 10; busy falls on that same cycle; done lasts 1 cycle.
- start=0, limit=9, step=4, repeat=2 -> q sequence 0,4,8,0,4,8,0,4,8; pass_cnt = 0,0,0,1,1,1,2,2,2; done after the 9th value.
- start=3, limit=15, step=1, repeat=0 with pause high for 3 cycles at q=7 -> q holds 7 for those cycles; counting resumes 8..15 after pause drops; no wrap to 0; done after 15.
- abort at q=5 during the second pass -> busy=0 next cycle; q stays 5; pass_cnt=1; done never pulses. A start in the same cycle as abort is ignored.
- start with start=9, limit=4; then start with step=0 -> cfg_err pulses once each time; busy stays 0; q unchanged.
- Drive rst_n low asynchronously mid-run at q=6 -> q=0 and busy=0 immediately, without waiting for a clk edge; done never pulses. Change cfg_* while busy -> sequence unaffected.
